// File: rtl/jtframe_romload.sv
// rtl/jtframe_romload.sv - ioctl byte stream to SDRAM programming-port write sequencer
// Optional byte-swap region enabled by defining JTFRAME_ROMLOAD_SWAP_EN.
module jtframe_romload #(
    parameter int          FIFO_AW    = 2,
    parameter int          TAIL       = 16,
    parameter logic [21:0] SWAP_START = 22'h0,
    parameter logic [21:0] SWAP_END   = 22'h0
) (
    input  logic        clk_rom,
    input  logic        rst_n,
    input  logic        downloading,
    input  logic [21:0] ioctl_addr,
    input  logic [7:0]  ioctl_data,
    input  logic        ioctl_wr,
    input  logic        prog_rdy,
    output logic [21:0] prog_addr,
    output logic [7:0]  prog_data,
    output logic [1:0]  prog_mask,
    output logic        prog_we,
    output logic        dwnld_busy,
    output logic        ovf
);
    localparam int DEPTH = 1 << FIFO_AW;

    typedef enum logic [1:0] {IDLE, WRITE, TAIL_ST} state_t;

    state_t             state, state_nxt;
    logic [29:0]        mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [FIFO_AW:0]   count;
    logic [7:0]         cnt, cnt_nxt;
    logic               dl_d;
    logic               fifo_empty, fifo_full, have, push, pop, drop;
    logic [21:0]        head_addr, eff_addr;
    logic [7:0]         head_data;
    logic [21:0]        addr_nxt;
    logic [7:0]         data_nxt;
    logic [1:0]         mask_nxt;
    logic               we_nxt, busy_nxt;

    // An empty FIFO is bypassed so a lone byte reaches prog_we one cycle later.
    always_comb begin
        fifo_empty = (count == '0);
        fifo_full  = (count == (FIFO_AW+1)'(DEPTH));
        have       = !fifo_empty || ioctl_wr;
        if (fifo_empty) begin
            head_addr = ioctl_addr;
            head_data = ioctl_data;
        end else begin
            head_addr = mem[rd_ptr][29:8];
            head_data = mem[rd_ptr][7:0];
        end
    end

`ifdef JTFRAME_ROMLOAD_SWAP_EN
    logic in_swap;
    always_comb begin
        in_swap  = (head_addr >= SWAP_START) && (head_addr < SWAP_END);
        eff_addr = head_addr ^ {21'b0, in_swap};
    end
`else
    assign eff_addr = head_addr;
`endif

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        addr_nxt  = prog_addr;
        data_nxt  = prog_data;
        mask_nxt  = prog_mask;
        we_nxt    = prog_we;
        busy_nxt  = dwnld_busy;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (have) begin
                    pop       = 1'b1;
                    addr_nxt  = {1'b0, eff_addr[21:1]};
                    data_nxt  = head_data;
                    mask_nxt  = eff_addr[0] ? 2'b01 : 2'b10;
                    we_nxt    = 1'b1;
                    state_nxt = WRITE;
                end else if (!downloading && dwnld_busy) begin
                    cnt_nxt   = 8'(TAIL);
                    state_nxt = TAIL_ST;
                end
            end
            WRITE: begin
                if (prog_rdy) begin
                    we_nxt    = 1'b0;
                    state_nxt = IDLE;
                end
            end
            TAIL_ST: begin
                if (downloading || have) begin
                    state_nxt = IDLE;
                end else if (cnt == 8'd1) begin
                    busy_nxt  = 1'b0;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (downloading) busy_nxt = 1'b1;
        push = ioctl_wr && (!fifo_full || pop);
        drop = ioctl_wr && !push;
    end

    always_ff @(posedge clk_rom) begin
        if (push) mem[wr_ptr] <= {ioctl_addr, ioctl_data};
    end

    always_ff @(posedge clk_rom or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            cnt        <= '0;
            dl_d       <= 1'b0;
            prog_addr  <= '0;
            prog_data  <= '0;
            prog_mask  <= '0;
            prog_we    <= 1'b0;
            dwnld_busy <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            dl_d       <= downloading;
            prog_addr  <= addr_nxt;
            prog_data  <= data_nxt;
            prog_mask  <= mask_nxt;
            prog_we    <= we_nxt;
            dwnld_busy <= busy_nxt;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
            // A drop in the same cycle as the download restart still flags.
            if (downloading && !dl_d) ovf <= 1'b0;
            if (drop)                 ovf <= 1'b1;
        end
    end
endmodule

// File: tb/tb_jtframe_romload.sv
// tb/tb_jtframe_romload.sv - directed self-checking bench for jtframe_romload
module tb_jtframe_romload;
    logic        clk_rom = 1'b0;
    logic        rst_n;
    logic        downloading;
    logic [21:0] ioctl_addr;
    logic [7:0]  ioctl_data;
    logic        ioctl_wr;
    logic        prog_rdy;
    logic [21:0] prog_addr;
    logic [7:0]  prog_data;
    logic [1:0]  prog_mask;
    logic        prog_we;
    logic        dwnld_busy;
    logic        ovf;

    int checks = 0;
    int errors = 0;

    jtframe_romload #(
        .FIFO_AW(2), .TAIL(16), .SWAP_START(22'h100), .SWAP_END(22'h200)
    ) dut (
        .clk_rom(clk_rom), .rst_n(rst_n), .downloading(downloading),
        .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data), .ioctl_wr(ioctl_wr),
        .prog_rdy(prog_rdy), .prog_addr(prog_addr), .prog_data(prog_data),
        .prog_mask(prog_mask), .prog_we(prog_we), .dwnld_busy(dwnld_busy), .ovf(ovf)
    );

    always #5 clk_rom = ~clk_rom;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change on the falling edge, so each call covers one sampled cycle.
    task automatic send(input logic [21:0] a, input logic [7:0] d);
        ioctl_addr = a;
        ioctl_data = d;
        ioctl_wr   = 1'b1;
        @(negedge clk_rom);
        ioctl_wr   = 1'b0;
    endtask

    task automatic wait_we();
        for (int i = 0; i < 50 && !prog_we; i++) @(negedge clk_rom);
        check("we_timeout", {31'b0, prog_we}, 1);
    endtask

    task automatic ack();
        prog_rdy = 1'b1;
        @(negedge clk_rom);
        prog_rdy = 1'b0;
    endtask

    task automatic expect_write(input string tag, input logic [21:0] a, input logic [7:0] d,
                                input logic [1:0] m);
        wait_we();
        check({tag, "_addr"}, {10'b0, prog_addr}, {10'b0, a});
        check({tag, "_data"}, {24'b0, prog_data}, {24'b0, d});
        check({tag, "_mask"}, {30'b0, prog_mask}, {30'b0, m});
        repeat (2) @(negedge clk_rom);
        ack();
        check({tag, "_we_fall"}, {31'b0, prog_we}, 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk_rom);
        rst_n = 1'b1;
        @(negedge clk_rom);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int seen;
        rst_n = 1'b0; downloading = 1'b0; ioctl_addr = '0; ioctl_data = '0;
        ioctl_wr = 1'b0; prog_rdy = 1'b0;
        do_reset();
        check("rst_we", {31'b0, prog_we}, 0);
        check("rst_addr", {10'b0, prog_addr}, 0);
        check("rst_busy", {31'b0, dwnld_busy}, 0);
        check("rst_ovf", {31'b0, ovf}, 0);
        check("rst_mask", {30'b0, prog_mask}, 0);

        // single byte, one-cycle latency, hold until ack
        downloading = 1'b1;
        @(negedge clk_rom);
        check("busy_set", {31'b0, dwnld_busy}, 1);
        send(22'h000003, 8'hA5);
        check("sb_we", {31'b0, prog_we}, 1);
        check("sb_addr", {10'b0, prog_addr}, 22'h000001);
        check("sb_mask", {30'b0, prog_mask}, 2'b01);
        check("sb_data", {24'b0, prog_data}, 8'hA5);
        repeat (3) @(negedge clk_rom);
        check("sb_hold_we", {31'b0, prog_we}, 1);
        check("sb_hold_data", {24'b0, prog_data}, 8'hA5);
        ack();
        check("sb_we_fall", {31'b0, prog_we}, 0);

        // back-to-back: byte 6 dropped
        for (int i = 0; i < 6; i++) send(22'h10 + 22'(i), 8'h30 + 8'(i));
        check("b2b_ovf", {31'b0, ovf}, 1);
        for (int i = 0; i < 5; i++)
            expect_write($sformatf("b2b%0d", i), (22'h10 + 22'(i)) >> 1, 8'h30 + 8'(i),
                         i[0] ? 2'b01 : 2'b10);
        repeat (4) @(negedge clk_rom);
        check("b2b_no_6th", {31'b0, prog_we}, 0);
        check("ovf_sticky", {31'b0, ovf}, 1);

        // ovf clears one cycle after downloading rises
        downloading = 1'b0;
        @(negedge clk_rom);
        downloading = 1'b1;
        @(negedge clk_rom);
        check("ovf_clear", {31'b0, ovf}, 0);

        // busy tail with two pending writes
        send(22'h20, 8'h11);
        send(22'h21, 8'h22);
        downloading = 1'b0;
        expect_write("tail0", 22'h10, 8'h11, 2'b10);
        expect_write("tail1", 22'h10, 8'h22, 2'b01);
        repeat (16) @(negedge clk_rom);
        check("tail_busy_m17", {31'b0, dwnld_busy}, 1);
        @(negedge clk_rom);
        check("tail_busy_m18", {31'b0, dwnld_busy}, 0);

        // re-raise downloading during tail
        downloading = 1'b1;
        send(22'h30, 8'h33);
        downloading = 1'b0;
        expect_write("rr", 22'h18, 8'h33, 2'b10);
        repeat (5) @(negedge clk_rom);
        downloading = 1'b1;
        @(negedge clk_rom);
        downloading = 1'b0;
        repeat (11) @(negedge clk_rom);
        check("rr_busy_held", {31'b0, dwnld_busy}, 1);
        repeat (12) @(negedge clk_rom);
        check("rr_busy_fall", {31'b0, dwnld_busy}, 0);

        // swap region boundaries
        downloading = 1'b1;
        send(22'h100, 8'h44);
`ifdef JTFRAME_ROMLOAD_SWAP_EN
        expect_write("swap_in", 22'h80, 8'h44, 2'b01);
`else
        expect_write("swap_in", 22'h80, 8'h44, 2'b10);
`endif
        send(22'h200, 8'h55);
        expect_write("swap_end", 22'h100, 8'h55, 2'b10);
        send(22'h0FF, 8'h66);
`ifdef JTFRAME_ROMLOAD_SWAP_EN
        expect_write("swap_below", 22'h7F, 8'h66, 2'b01);
`else
        expect_write("swap_below", 22'h7F, 8'h66, 2'b01);
`endif

        // spurious ack in IDLE
        prog_rdy = 1'b1;
        @(negedge clk_rom);
        prog_rdy = 1'b0;
        check("spur_we", {31'b0, prog_we}, 0);
        send(22'h0A, 8'h77);
        check("spur_next_we", {31'b0, prog_we}, 1);
        expect_write("spur", 22'h05, 8'h77, 2'b10);

        // reset mid-write with 3 queued
        for (int i = 0; i < 4; i++) send(22'h40 + 22'(i), 8'h80 + 8'(i));
        downloading = 1'b0;
        check("rmw_we_pre", {31'b0, prog_we}, 1);
        #2 rst_n = 1'b0;
        #1;
        check("rmw_we", {31'b0, prog_we}, 0);
        check("rmw_addr", {10'b0, prog_addr}, 0);
        check("rmw_data", {24'b0, prog_data}, 0);
        check("rmw_mask", {30'b0, prog_mask}, 0);
        check("rmw_busy", {31'b0, dwnld_busy}, 0);
        @(negedge clk_rom);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk_rom);
            if (prog_we) seen++;
        end
        check("rmw_no_write", seen, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
